// File: rtl/lcd_pkg.sv
// Shared definitions for the LCD MMIO bridge: FSM encoding, slow-command
// constants and the queued entry layout.
package lcd_pkg;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_SETUP = 3'd1;
  localparam logic [2:0] S_PULSE = 3'd2;
  localparam logic [2:0] S_HOLD  = 3'd3;
  localparam logic [2:0] S_WAIT  = 3'd4;

  localparam logic [7:0] CMD_CLEAR     = 8'h01;
  localparam logic [7:0] CMD_HOME_MASK = 8'h02;

  typedef struct packed {
    logic       rs;
    logic [7:0] data;
  } lcd_entry_t;

  // Clear display (0x01) and return home (0x02/0x03) need the long execute wait.
  function automatic logic is_slow_cmd(input logic rs, input logic [7:0] data);
    return !rs && ((data == CMD_CLEAR) || ((data & 8'hFE) == CMD_HOME_MASK));
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock show-ahead FIFO; push is ignored when full, pop when empty.
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 8
) (
  input  logic                                         clk,
  input  logic                                         rst_n,
  input  logic                                         push,
  input  logic                                         pop,
  input  logic [WIDTH-1:0]                             wdata,
  output logic [WIDTH-1:0]                             rdata,
  output logic                                         full,
  output logic                                         empty,
  output logic [((DEPTH > 1) ? $clog2(DEPTH) : 1):0]   count
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  // Full is judged on the registered count, before any same-cycle pop.
  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/lcd_mmio_bridge.sv
// MMIO-to-HD44780 bridge: buffers CPU byte writes and replays them on the
// LCD bus with setup / enable / hold / execute timing.
module lcd_mmio_bridge
  import lcd_pkg::*;
#(
  parameter int unsigned DEPTH        = 8,
  parameter int unsigned SETUP_CYCLES = 8,
  parameter int unsigned EN_CYCLES    = 50,
  parameter int unsigned HOLD_CYCLES  = 4,
  parameter int unsigned EXEC_CYCLES  = 4000,
  parameter int unsigned CLEAR_CYCLES = 164000
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       wr_en,
  input  logic                       wr_rs,
  input  logic [7:0]                 wr_data,
  input  logic                       ovf_clr,
  output logic [7:0]                 lcd_data,
  output logic                       lcd_rs,
  output logic                       lcd_rw,
  output logic                       lcd_en,
  output logic                       busy,
  output logic                       full,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       overflow
);

  localparam int unsigned CW     = $clog2(DEPTH) + 1;
  localparam int unsigned MAX_A  = (SETUP_CYCLES > EN_CYCLES) ? SETUP_CYCLES : EN_CYCLES;
  localparam int unsigned MAX_B  = (HOLD_CYCLES > EXEC_CYCLES) ? HOLD_CYCLES : EXEC_CYCLES;
  localparam int unsigned MAX_C  = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int unsigned MAX_CY = (MAX_C > CLEAR_CYCLES) ? MAX_C : CLEAR_CYCLES;
  localparam int unsigned TW     = (MAX_CY < 2) ? 1 : $clog2(MAX_CY);

  logic [2:0]    state_q, state_d;
  logic [TW-1:0] cnt_q, cnt_d;
  logic          en_q, en_d;
  logic          rs_q, rs_d;
  logic [7:0]    data_q, data_d;
  logic          ovf_q, ovf_d;
  logic          pop_c;
  logic          cnt_zero_c;

  lcd_entry_t    wr_entry;
  lcd_entry_t    head;
  logic          fifo_full;
  logic          fifo_empty;
  logic [CW-1:0] fifo_count;

  assign wr_entry = '{rs: wr_rs, data: wr_data};

  sync_fifo #(
    .WIDTH ($bits(lcd_entry_t)),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (wr_en),
    .pop   (pop_c),
    .wdata (wr_entry),
    .rdata (head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  assign cnt_zero_c = (cnt_q == '0);

  // Next-state, shared down-counter and LCD bus values.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    en_d    = en_q;
    rs_d    = rs_q;
    data_d  = data_q;
    pop_c   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!fifo_empty) begin
          pop_c   = 1'b1;
          rs_d    = head.rs;
          data_d  = head.data;
          cnt_d   = TW'(SETUP_CYCLES - 1);
          state_d = S_SETUP;
        end
      end
      S_SETUP: begin
        if (cnt_zero_c) begin
          en_d    = 1'b1;
          cnt_d   = TW'(EN_CYCLES - 1);
          state_d = S_PULSE;
        end else begin
          cnt_d = cnt_q - TW'(1);
        end
      end
      S_PULSE: begin
        if (cnt_zero_c) begin
          en_d    = 1'b0;
          cnt_d   = TW'(HOLD_CYCLES - 1);
          state_d = S_HOLD;
        end else begin
          cnt_d = cnt_q - TW'(1);
        end
      end
      S_HOLD: begin
        if (cnt_zero_c) begin
          cnt_d   = is_slow_cmd(rs_q, data_q) ? TW'(CLEAR_CYCLES - 1) : TW'(EXEC_CYCLES - 1);
          state_d = S_WAIT;
        end else begin
          cnt_d = cnt_q - TW'(1);
        end
      end
      S_WAIT: begin
        if (cnt_zero_c) begin
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q - TW'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
        en_d    = 1'b0;
      end
    endcase
  end

  // A dropped write outranks a same-cycle clear.
  always_comb begin
    ovf_d = ovf_q;
    if (wr_en && fifo_full) ovf_d = 1'b1;
    else if (ovf_clr)       ovf_d = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      en_q    <= 1'b0;
      rs_q    <= 1'b0;
      data_q  <= 8'h00;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      en_q    <= en_d;
      rs_q    <= rs_d;
      data_q  <= data_d;
      ovf_q   <= ovf_d;
    end
  end

  assign lcd_data = data_q;
  assign lcd_rs   = rs_q;
  assign lcd_rw   = 1'b0;
  assign lcd_en   = en_q;
  assign overflow = ovf_q;
  assign full     = fifo_full;
  assign count    = fifo_count;
  assign busy     = (state_q != S_IDLE) || !fifo_empty;

endmodule

// File: tb/tb_lcd_mmio_bridge.sv
// Bench for lcd_mmio_bridge: timeline model of queued LCD transfers plus
// directed scenarios with hand-derived expectations.
module tb_lcd_mmio_bridge;

  localparam int DEPTH = 4;
  localparam int SETUP = 2;
  localparam int EN    = 3;
  localparam int HOLD  = 1;
  localparam int EXEC  = 5;
  localparam int CLEAR = 20;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       wr_en;
  logic       wr_rs;
  logic [7:0] wr_data;
  logic       ovf_clr;
  logic [7:0] lcd_data;
  logic       lcd_rs;
  logic       lcd_rw;
  logic       lcd_en;
  logic       busy;
  logic       full;
  logic [2:0] count;
  logic       overflow;

  int n_checks = 0;
  int n_errors = 0;

  lcd_mmio_bridge #(
    .DEPTH        (DEPTH),
    .SETUP_CYCLES (SETUP),
    .EN_CYCLES    (EN),
    .HOLD_CYCLES  (HOLD),
    .EXEC_CYCLES  (EXEC),
    .CLEAR_CYCLES (CLEAR)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .wr_en    (wr_en),
    .wr_rs    (wr_rs),
    .wr_data  (wr_data),
    .ovf_clr  (ovf_clr),
    .lcd_data (lcd_data),
    .lcd_rs   (lcd_rs),
    .lcd_rw   (lcd_rw),
    .lcd_en   (lcd_en),
    .busy     (busy),
    .full     (full),
    .count    (count),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: a queue of pending bytes and the timeline of the transfer in flight.
  logic [8:0] mq[$];
  logic [8:0] m_head;
  bit         m_active = 0;
  int         mcyc = 0;
  int         t_pop = 0;
  int         t_done = 0;
  logic       m_en = 0, m_rs = 0, m_ovf = 0;
  logic [7:0] m_data = 8'h00;
  bit         m_full_pre;

  function automatic int wait_len(input logic rs, input logic [7:0] d);
    if (!rs && (d == 8'h01 || d == 8'h02 || d == 8'h03)) return CLEAR;
    return EXEC;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mq.delete();
      m_active = 0;
      m_en = 0; m_rs = 0; m_data = 8'h00; m_ovf = 0;
    end else begin
      mcyc++;
      m_full_pre = (mq.size() == DEPTH);
      if (!m_active && mq.size() > 0) begin
        m_head   = mq.pop_front();
        m_rs     = m_head[8];
        m_data   = m_head[7:0];
        m_active = 1;
        t_pop    = mcyc;
        t_done   = mcyc + SETUP + EN + HOLD + wait_len(m_rs, m_data);
      end else if (m_active && mcyc == t_done) begin
        m_active = 0;
      end
      m_en = m_active && (mcyc >= t_pop + SETUP) && (mcyc < t_pop + SETUP + EN);
      if (wr_en) begin
        if (m_full_pre) m_ovf = 1;
        else mq.push_back({wr_rs, wr_data});
      end
      if (ovf_clr && !(wr_en && m_full_pre)) m_ovf = 0;
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      chk("lcd_en",   int'(lcd_en),   int'(m_en));
      chk("lcd_rs",   int'(lcd_rs),   int'(m_rs));
      chk("lcd_data", int'(lcd_data), int'(m_data));
      chk("lcd_rw",   int'(lcd_rw),   0);
      chk("count",    int'(count),    mq.size());
      chk("full",     int'(full),     int'(mq.size() == DEPTH));
      chk("busy",     int'(busy),     int'(m_active || mq.size() > 0));
      chk("overflow", int'(overflow), int'(m_ovf));
    end
  end

  // Bytes seen by the LCD, captured at each enable rise.
  logic [7:0] rx[$];
  logic       prev_en = 0;
  always @(negedge clk) begin
    if (lcd_en && !prev_en) rx.push_back(lcd_data);
    prev_en = lcd_en;
  end

  task automatic run_until_idle(input int bound, output int n);
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (busy && n < bound);
    chk("idle_timeout", int'(busy), 0);
  endtask

  task automatic single_write_timing(input string tag);
    @(negedge clk);
    wr_en = 1; wr_rs = 1; wr_data = 8'h41;
    @(negedge clk);
    wr_en = 0;
    chk({tag, "_count_after_push"}, int'(count), 1);
    chk({tag, "_busy_after_push"}, int'(busy), 1);
    for (int k = 1; k <= 13; k++) begin
      @(posedge clk); #1;
      if (k == 1) begin
        chk({tag, "_rs_at_pop"}, int'(lcd_rs), 1);
        chk({tag, "_data_at_pop"}, int'(lcd_data), 8'h41);
        chk({tag, "_count_at_pop"}, int'(count), 0);
      end
      chk($sformatf("%s_en_k%0d", tag, k), int'(lcd_en), int'(k >= 3 && k <= 5));
      chk($sformatf("%s_busy_k%0d", tag, k), int'(busy), int'(k <= 11));
    end
  endtask

  task automatic wait_measure(input logic rs, input logic [7:0] d, input int exp_n);
    int n;
    @(negedge clk);
    wr_en = 1; wr_rs = rs; wr_data = d;
    @(negedge clk);
    wr_en = 0;
    run_until_idle(200, n);
    chk($sformatf("busy_len_rs%0d_%02h", rs, d), n, exp_n);
  endtask

  int n;
  int exp_cnt[6] = '{1, 1, 2, 3, 4, 4};

  initial begin
    rst_n = 0; wr_en = 0; wr_rs = 0; wr_data = 8'h00; ovf_clr = 0;
    repeat (3) @(negedge clk);
    rst_n = 1;
    chk("rst_count", int'(count), 0);
    chk("rst_en", int'(lcd_en), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_ovf", int'(overflow), 0);
    chk("rst_data", int'(lcd_data), 0);
    repeat (5) @(negedge clk);

    // Single data write: pop one edge later, E high for three cycles.
    rx.delete();
    single_write_timing("single");
    chk("single_rx_size", rx.size(), 1);

    // Clear/home commands wait CLEAR, everything else EXEC.
    wait_measure(1'b0, 8'h01, 1 + SETUP + EN + HOLD + CLEAR);
    wait_measure(1'b0, 8'h38, 1 + SETUP + EN + HOLD + EXEC);
    wait_measure(1'b0, 8'h02, 27);
    wait_measure(1'b0, 8'h03, 27);
    wait_measure(1'b0, 8'h00, 12);
    wait_measure(1'b0, 8'h04, 12);
    wait_measure(1'b1, 8'h01, 12);

    // Six back-to-back writes, then overflow clear with and without a drop.
    rx.delete();
    @(negedge clk);
    for (int i = 0; i < 6; i++) begin
      wr_en = 1; wr_rs = 1; wr_data = 8'(8'h30 + i);
      @(negedge clk);
      chk($sformatf("burst_count_%0d", i), int'(count), exp_cnt[i]);
      chk($sformatf("burst_ovf_%0d", i), int'(overflow), int'(i == 5));
    end
    wr_en = 0; ovf_clr = 1;
    @(negedge clk);
    chk("ovf_clr_alone", int'(overflow), 0);
    chk("still_full", int'(full), 1);
    wr_en = 1; wr_data = 8'h36; ovf_clr = 1;
    @(negedge clk);
    chk("ovf_clr_vs_drop", int'(overflow), 1);
    wr_en = 0; ovf_clr = 0;
    run_until_idle(500, n);
    chk("burst_rx_size", rx.size(), 5);
    for (int i = 0; i < 5 && i < rx.size(); i++)
      chk($sformatf("burst_rx_%0d", i), int'(rx[i]), 8'h30 + i);

    // Write lands on the edge that pops the only entry.
    rx.delete();
    @(negedge clk);
    wr_en = 1; wr_rs = 1; wr_data = 8'h50;
    @(negedge clk);
    chk("pp_count_a", int'(count), 1);
    wr_data = 8'h51;
    @(negedge clk);
    wr_en = 0;
    chk("pp_count_b", int'(count), 1);
    run_until_idle(200, n);
    chk("pp_rx_size", rx.size(), 2);
    if (rx.size() == 2) begin
      chk("pp_rx_0", int'(rx[0]), 8'h50);
      chk("pp_rx_1", int'(rx[1]), 8'h51);
    end

    // Reset in the middle of an enable pulse with two entries queued.
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      wr_en = 1; wr_rs = 1; wr_data = 8'(8'h60 + i);
      @(negedge clk);
    end
    wr_en = 0;
    chk("pre_rst_count", int'(count), 2);
    @(posedge clk); #1;
    chk("pre_rst_en", int'(lcd_en), 1);
    @(posedge clk); #2;
    rst_n = 0;
    #1;
    chk("mid_rst_en", int'(lcd_en), 0);
    chk("mid_rst_count", int'(count), 0);
    chk("mid_rst_busy", int'(busy), 0);
    chk("mid_rst_data", int'(lcd_data), 0);
    chk("mid_rst_rs", int'(lcd_rs), 0);
    repeat (2) @(negedge clk);
    rst_n = 1;
    rx.delete();
    repeat (40) @(negedge clk);
    chk("post_rst_no_pulses", rx.size(), 0);
    chk("post_rst_busy", int'(busy), 0);

    // First write after reset keeps the normal latency.
    single_write_timing("after_rst");
    chk("after_rst_rx", rx.size(), 1);

    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/lcd_mmio_bridge.md
LCD_MMIO_BRIDGE -- requirements
Module: lcd_mmio_bridge

Interface
REQ-001 Parameters SHALL be: DEPTH, 8, FIFO entries (power of 2, ≥2); SETUP_CYCLES, 8, RS/data-to-E-rise cycles; EN_CYCLES, 50, E-high cycles; HOLD_CYCLES, 4, data hold after E-fall; EXEC_CYCLES, 4000, generic command/data execute wait; CLEAR_CYCLES, 164000, wait for clear/home commands.
REQ-002 clk  input  1  system clock, all logic on rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 wr_en  input  1  one-cycle MMIO write strobe (CPU store with address bit 31 set, byte lane 0).
REQ-005 wr_rs  input  1  register select from address bit 0 (0 = command, 1 = data).
REQ-006 wr_data  input  8  byte to send.
REQ-007 ovf_clr  input  1  clears sticky overflow flag.
REQ-008 lcd_data  output  8  LCD data bus, registered.
REQ-009 lcd_rs  output  1  LCD register select, registered.
REQ-010 lcd_rw  output  1  constant 0 (write-only).
REQ-011 lcd_en  output  1  LCD enable strobe, registered.
REQ-012 busy  output  1  high when FSM not IDLE or FIFO non-empty.
REQ-013 full  output  1  FIFO count equals DEPTH.
REQ-014 count  output  $clog2(DEPTH)+1  FIFO occupancy.
REQ-015 overflow  output  1  sticky, write attempted while full.

Function
REQ-016 Every wr_en cycle with full low SHALL push {wr_rs, wr_data}; back-to-back writes on consecutive cycles SHALL all be captured up to DEPTH.
REQ-017 full SHALL be evaluated before any same-cycle pop; a write while full is dropped and sets overflow, even if a pop occurs that cycle.
REQ-018 overflow SHALL clear on ovf_clr; a simultaneous overflow event wins (flag stays 1).
REQ-019 FSM states SHALL be IDLE, SETUP, PULSE, HOLD, WAIT, with one down-counter shared across states.
REQ-020 IDLE: if FIFO non-empty, pop, load lcd_rs/lcd_data from head, go SETUP with SETUP_CYCLES-1; else stay.
REQ-021 SETUP: on counter 0 assert lcd_en, go PULSE with EN_CYCLES-1.
REQ-022 PULSE: on counter 0 deassert lcd_en, go HOLD with HOLD_CYCLES-1.
REQ-023 HOLD: on counter 0 go WAIT with CLEAR_CYCLES-1 if the entry had rs=0 and data in {0x01,0x02,0x03}, else EXEC_CYCLES-1.
REQ-024 WAIT: on counter 0 go IDLE; next entry may be popped on the following edge.
REQ-025 lcd_data and lcd_rs SHALL remain constant from pop until the next pop.
REQ-026 Latency: write captured at edge k into empty FIFO with FSM idle → pop at edge k+1, lcd_en rises at edge k+1+SETUP_CYCLES, high for exactly EN_CYCLES cycles.
REQ-027 Simultaneous push and pop on a non-empty, non-full FIFO SHALL leave count unchanged; pointers wrap modulo DEPTH.
REQ-028 busy SHALL be combinational from state and count; full, count, and overflow SHALL reflect register state after each edge.

Reset
REQ-029 rst_n low SHALL immediately force lcd_en=0, lcd_rs=0, lcd_data=0x00, overflow=0, FIFO empty (count 0), FSM IDLE, counter 0, including mid-pulse.
REQ-030 After rst_n deasserts, the first write SHALL follow REQ-026 timing with no residual entries.

Structure
REQ-031 Package lcd_pkg SHALL hold the FSM state encoding and the clear/home command constants (0x01, 0x02 mask).
REQ-032 FIFO SHALL be a sub-module sync_fifo (parameterised width/depth, push/pop/full/empty/count); FSM, counter, and output registers SHALL be in lcd_mmio_bridge.

Verification (overrides: DEPTH=4, SETUP=2, EN=3, HOLD=1, EXEC=5, CLEAR=20)
REQ-033 Single write rs=1 data=0x41 at edge 10 → lcd_rs=1, lcd_data=0x41 from edge 11; lcd_en high edges 13–15; busy low from edge 22.
REQ-034 Command 0x01 (rs=0) → WAIT lasts 20 cycles; 0x38 → WAIT lasts 5 cycles.
REQ-035 Six back-to-back writes 0x30..0x35 with idle FSM → first pops immediately, next four buffered, count peaks at 4, 0x35 dropped, overflow=1; the LCD receives 0x30..0x34 in order.
REQ-036 ovf_clr pulse with no write → overflow=0; ovf_clr coincident with dropped write → overflow stays 1.
REQ-037 rst_n asserted during PULSE with 2 entries queued → lcd_en=0 immediately, count=0, busy=0; no further E pulses after release.
REQ-038 Write on the same cycle IDLE pops the last entry → count stays 1, both bytes emitted in order.
